// File: rtl/ps2_pkg.sv
// Shared constants and receiver state encoding for the PS/2 scan-code receiver.
package ps2_pkg;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam int         PS2_CODE_W = 10;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// First-word-fall-through FIFO; rdata shows the head entry whenever empty is low.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop frees the slot the same cycle, so a full FIFO can still accept
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + glitch filter, framed RX with timeout,
// E0/F0 prefix decoding and a FWFT output FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [PS2_CODE_W-1:0]         code_data,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s;
  logic                   filt_clk, fall;
  logic [FW-1:0]          filt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end
  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // fall fires in the cycle the filter commits to low; data is sampled alongside
  assign fall = filt_clk && !clk_s && (filt_cnt == FW'(FILTER_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      filt_clk <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  rx_state_e     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit, byte_ok;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      byte_ok    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      byte_ok    <= 1'b0;
      if (state != RX_IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_err <= 1'b1;
        state     <= RX_IDLE;
      end else if (fall) begin
        tmo_cnt <= '0;
        case (state)
          RX_IDLE: begin
            if (!dat_s) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          RX_DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par_bit <= dat_s;
            state   <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
            if (!dat_s)                    frame_err  <= 1'b1;
            else if (!(^shreg ^ par_bit))  parity_err <= 1'b1;
            else                           byte_ok    <= 1'b1;
          end
          default: state <= RX_IDLE;
        endcase
      end else if (state != RX_IDLE) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  // shreg is untouched while IDLE, so it still holds the byte during byte_ok
  logic                  exp_flag, brk_flag, push, full, empty;
  logic [PS2_CODE_W-1:0] head;

  assign push = byte_ok && shreg != PS2_EXT && shreg != PS2_BRK;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_flag <= 1'b0;
      brk_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (parity_err || frame_err) begin
        exp_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_ok) begin
        if (shreg == PS2_EXT)      exp_flag <= 1'b1;
        else if (shreg == PS2_BRK) brk_flag <= 1'b1;
        else begin
          exp_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
      if (push && full && !code_ready) overflow <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH(PS2_CODE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({exp_flag, brk_flag, shreg}),
    .pop   (code_ready),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign code_valid = !empty;
  assign code_data  = empty ? '0 : head;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomized PS/2 frame stimulus checked against a queue-based decoder model.
module tb_ps2_rx_fifo;
  localparam int S = 3, F = 4, T = 200, D = 8, HALF = 12;

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, code_ready = 1'b0;
  logic [9:0] code_data;
  logic       code_valid, overflow, parity_err, frame_err;
  logic [3:0] fifo_count;

  ps2_rx_fifo #(.SYNC_STAGES(S), .FILTER_LEN(F), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code_data(code_data), .code_valid(code_valid), .code_ready(code_ready),
    .fifo_count(fifo_count), .overflow(overflow),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, t_fall = 0;
  int n_perr = 0, n_ferr = 0, vld_cyc = 0, exp_perr = 0, exp_ferr = 0;
  logic [9:0] mq[$];
  bit m_exp = 0, m_brk = 0, m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // consumer side: every accepted head entry must match the model's oldest code
  always @(negedge clk) if (!rst) begin
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if (code_valid) vld_cyc++;
    if (code_valid && code_ready) begin
      if (mq.size() == 0) chk("unexp_code", 32'(code_data), 32'hffff_ffff);
      else begin
        chk("code", 32'(code_data), 32'(mq[0]));
        void'(mq.pop_front());
      end
    end
  end

  function automatic void m_err(input bit is_par);
    if (is_par) exp_perr++; else exp_ferr++;
    m_exp = 0; m_brk = 0;
  endfunction

  function automatic void m_frame(input logic [7:0] b, input bit bad_par, input bit stop);
    if (!stop)            m_err(0);
    else if (bad_par)     m_err(1);
    else if (b == 8'hE0)  m_exp = 1;
    else if (b == 8'hF0)  m_brk = 1;
    else begin
      if (mq.size() < D) mq.push_back({m_exp, m_brk, b});
      else m_ovf = 1;
      m_exp = 0; m_brk = 0;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fall(input bit d);
    ps2_data = d;
    tick(HALF);
    ps2_clk = 1'b0;
    t_fall = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic glitch();
    tick(HALF);
    ps2_clk = 1'b0;
    tick(F - 1);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit stop);
    return {stop, ~(^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) fall(bits[i]);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit stop = 1,
                            input int gl = -1);
    logic [10:0] bits;
    bits = frame_bits(b, bad_par, stop);
    for (int i = 0; i < 11; i++) begin
      if (i == gl) glitch();
      if (i == 10) m_frame(b, bad_par, stop);
      fall(bits[i]);
    end
  endtask

  task automatic wait_drain();
    code_ready = 1'b1;
    tick(10);
    for (int i = 0; i < 400 && (mq.size() != 0 || code_valid); i++) tick(1);
    chk("drain_left", 32'(mq.size()), 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(code_valid), 0);
    chk({tag, "_count"}, 32'(fifo_count), 0);
    chk({tag, "_ovf"},   32'(overflow),   0);
    chk({tag, "_perr"},  32'(parity_err), 0);
    chk({tag, "_ferr"},  32'(frame_err),  0);
    chk({tag, "_data"},  32'(code_data),  0);
  endtask

  initial begin
    logic [10:0] bits;
    bit got;

    tick(5);
    @(negedge clk);
    chk_idle_outputs("rst");
    tick(1);
    rst = 1'b0;
    tick(5);

    // single make code, consumer always ready
    code_ready = 1'b1;
    vld_cyc = 0;
    send_frame(8'h1C);
    wait_drain();
    chk("make_vld_cycles", 32'(vld_cyc), 1);
    chk("make_perr", 32'(n_perr), 32'(exp_perr));
    chk("make_ferr", 32'(n_ferr), 32'(exp_ferr));

    // prefixed codes
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    send_frame(8'hF0); send_frame(8'h1C);
    wait_drain();
    chk("pfx_count", 32'(fifo_count), 0);

    // parity error, recovery, and expand flag cleared by the bad frame
    send_frame(8'h1C, 1);
    send_frame(8'h1C);
    send_frame(8'hE0);
    send_frame(8'h1C, 1);
    send_frame(8'h1C);
    wait_drain();
    chk("par_perr", 32'(n_perr), 32'(exp_perr));
    chk("par_ferr", 32'(n_ferr), 32'(exp_ferr));

    // overflow with back-pressure
    code_ready = 1'b0;
    for (int k = 1; k <= 9; k++) send_frame(8'(k));
    tick(10);
    chk("ovf_count", 32'(fifo_count), D);
    chk("ovf_flag", 32'(overflow), 32'(m_ovf));
    wait_drain();
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_empty", 32'(fifo_count), 0);

    // glitches in idle and mid-frame must not register as edges
    glitch();
    tick(20);
    chk("glitch_idle_ferr", 32'(n_ferr), 32'(exp_ferr));
    send_frame(8'h2A, 0, 1, 5);
    wait_drain();

    // timeout after start + 4 data bits, with a pending E0 that must be dropped
    send_frame(8'hE0);
    bits = frame_bits(8'h55, 0, 1);
    send_bits(bits, 0, 4);
    got = 0;
    for (int i = 0; i < T + 100 && !got; i++) begin
      @(negedge clk);
      if (frame_err) got = 1;
    end
    chk("tmo_seen", 32'(got), 1);
    chk("tmo_lat", 32'(cyc - t_fall), S + F + T);
    m_err(0);
    send_frame(8'h2A);
    wait_drain();
    chk("tmo_ferr", 32'(n_ferr), 32'(exp_ferr));

    // reset mid-frame with entries pending
    code_ready = 1'b0;
    send_frame(8'h16);
    send_frame(8'h1E);
    bits = frame_bits(8'h3C, 0, 1);
    send_bits(bits, 0, 6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    mq.delete(); m_exp = 0; m_brk = 0; m_ovf = 0;
    @(negedge clk);
    chk_idle_outputs("midrst");
    #1;
    send_bits(bits, 7, 10);
    tick(T + 50);
    chk("midrst_count", 32'(fifo_count), 0);
    chk("midrst_valid", 32'(code_valid), 0);
    chk("midrst_perr", 32'(n_perr), 32'(exp_perr));
    exp_ferr = n_ferr;
    m_exp = 0; m_brk = 0;
    code_ready = 1'b1;
    send_frame(8'h1C);
    wait_drain();

    // randomized traffic with error injection and random back-pressure
    for (int it = 0; it < 40; it++) begin
      logic [7:0] b;
      int r, e;
      r = int'($urandom % 6);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      e = int'($urandom % 10);
      code_ready = (mq.size() >= D - 2) ? 1'b1 : ($urandom % 4 != 0);
      case (e)
        0: send_frame(b, 1, 1);
        1: send_frame(b, 0, 0);
        2: send_frame(b, 1, 0);
        3: begin fall(1'b1); m_err(0); end
        default: send_frame(b);
      endcase
    end
    wait_drain();
    chk("rand_perr", 32'(n_perr), 32'(exp_perr));
    chk("rand_ferr", 32'(n_ferr), 32'(exp_ferr));
    chk("rand_ovf", 32'(overflow), 32'(m_ovf));

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
